// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin merge of NUM_SRC valid/ready streams into one registered output stage.
// A grant is held from arbitration until the last beat of that packet is accepted.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant; arbitrate among s_valid starting at r_rr_ptr
// ST_BUSY | locked to source r_g until its s_last beat is accepted
module stream_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            s_valid,
    output logic [NUM_SRC-1:0]            s_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SRC-1:0]            s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic [SRC_W-1:0]              m_src,
    output logic                          busy
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                r_state;
    logic [SRC_W-1:0]      r_rr_ptr;
    logic [SRC_W-1:0]      r_g;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic [SRC_W-1:0]      r_m_src;

    logic                  w_ready_o;
    logic                  w_accept;
    logic                  w_found;
    logic [SRC_W-1:0]      w_pick;
    logic [SRC_W-1:0]      w_cand;
    logic [SRC_W-1:0]      w_g_next;
    logic [DATA_WIDTH-1:0] w_sel_data;
    int                    w_idx;

    assign w_ready_o = m_ready | ~r_m_valid;
    assign w_accept  = (r_state == ST_BUSY) & s_valid[r_g] & w_ready_o;
    // Explicit wrap so non-power-of-two NUM_SRC returns to 0 after NUM_SRC-1.
    assign w_g_next  = (r_g == SRC_W'(NUM_SRC - 1)) ? '0 : r_g + SRC_W'(1);

    always_comb begin
        s_ready = '0;
        if (r_state == ST_BUSY) begin
            s_ready[r_g] = w_ready_o;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_g == SRC_W'(i)) begin
                w_sel_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // First requester at or after r_rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_SRC) begin
                w_idx = w_idx - NUM_SRC;
            end
            w_cand = SRC_W'(w_idx);
            if (!w_found && s_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_g       <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_src   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_g     <= w_pick;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && s_last[r_g]) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_g_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Output register drains during the IDLE bubble as well.
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_sel_data;
                r_m_last  <= s_last[r_g];
                r_m_src   <= r_g;
            end else if (w_ready_o) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign m_src   = r_m_src;
    assign busy    = (r_state == ST_BUSY);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle with a packet-level reference model.
module tb_stream_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [N-1:0]  s_valid, s_ready, s_last;
    logic [N*DW-1:0] s_data;
    logic          m_valid, m_ready, m_last, busy;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_src;

    stream_rr_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_src(m_src), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit        mdl_busy;
    int        mdl_g, mdl_ptr;
    bit        mdl_mv, mdl_ml;
    logic [DW-1:0] mdl_md;
    int        mdl_ms;
    bit        mdl_acc, mdl_acc_last;
    int        mdl_acc_src;

    // source stimulus state
    int rem[N], plen[N], bidx[N], gap[N], pkt_no[N];

    function automatic logic [DW-1:0] beat_data(int src, int pkt, int b);
        return {16'(pkt), 16'(b), 24'h0, 8'(8'hA0 + src)};
    endfunction

    task automatic model_reset();
        mdl_busy = 0; mdl_g = 0; mdl_ptr = 0;
        mdl_mv = 0; mdl_ml = 0; mdl_md = '0; mdl_ms = 0;
        mdl_acc = 0; mdl_acc_last = 0; mdl_acc_src = 0;
    endtask

    function automatic logic [N-1:0] mdl_ready();
        logic [N-1:0] r;
        r = '0;
        if (mdl_busy && (m_ready || !mdl_mv)) r[mdl_g] = 1'b1;
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit rdy, found;
        int idx;
        rdy = m_ready || !mdl_mv;
        mdl_acc = 0;
        if (!mdl_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (mdl_ptr + k) % N;
                if (!found && s_valid[idx]) begin
                    found = 1; mdl_g = idx; mdl_busy = 1;
                end
            end
            if (rdy) mdl_mv = 0;
        end else if (rdy && s_valid[mdl_g]) begin
            mdl_acc = 1; mdl_acc_src = mdl_g; mdl_acc_last = s_last[mdl_g];
            mdl_mv = 1; mdl_md = s_data[mdl_g*DW +: DW]; mdl_ml = s_last[mdl_g]; mdl_ms = mdl_g;
            if (s_last[mdl_g]) begin
                mdl_busy = 0;
                mdl_ptr  = (mdl_g + 1) % N;
            end
        end else if (rdy) begin
            mdl_mv = 0;
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; plen[i] = 1; bidx[i] = 0; gap[i] = 0; pkt_no[i] = 0;
        end
        s_valid = '0; s_last = '0; s_data = '0;
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            s_valid[i] = (rem[i] > 0) && (gap[i] == 0);
            s_last[i]  = (bidx[i] == plen[i] - 1);
            s_data[i*DW +: DW] = beat_data(i, pkt_no[i], bidx[i]);
        end
    endtask

    task automatic update_srcs();
        if (mdl_acc) begin
            if (mdl_acc_last) begin
                bidx[mdl_acc_src] = 0;
                pkt_no[mdl_acc_src]++;
                rem[mdl_acc_src]--;
            end else begin
                bidx[mdl_acc_src]++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_srcs();
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_srcs();
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive_srcs();
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got %b want 0", m_last); end
        n_checks++; if (m_src !== '0) begin n_fail++; $display("FAIL reset_m_src got %0d want 0", m_src); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (s_ready !== '0) begin n_fail++; $display("FAIL reset_s_ready got %b want 0000", s_ready); end
        rst_n = 1'b1;
        model_reset();
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got %b want 1", busy); end
        n_checks++; if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", s_ready); end
    endtask

    task automatic test_round_robin();
        int gs[$], gc[$];
        logic [7:0] gd[$];
        apply_reset();
        for (int i = 0; i < N; i++) begin rem[i] = 100; plen[i] = 1; end
        for (int c = 0; c < 12; c++) begin
            drive_srcs();
            tick();
            if (m_valid) begin gs.push_back(int'(m_src)); gc.push_back(c); gd.push_back(m_data[7:0]); end
            update_srcs();
        end
        n_checks++;
        if (gs.size() < 5) begin
            n_fail++; $display("FAIL rr_beat_count got %0d want >=5", gs.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++; if (gs[k] != k % N) begin n_fail++; $display("FAIL rr_src[%0d] got %0d want %0d", k, gs[k], k % N); end
                n_checks++; if (gc[k] != 1 + 2*k) begin n_fail++; $display("FAIL rr_cycle[%0d] got %0d want %0d", k, gc[k], 1 + 2*k); end
                n_checks++; if (gd[k] !== 8'(8'hA0 + k % N)) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", k, gd[k], 8'(8'hA0 + k % N)); end
            end
        end
    endtask

    task automatic test_packet_lock();
        int gs[$];
        logic [DW-1:0] gd[$];
        int exp_src[4] = '{1, 1, 1, 2};
        apply_reset();
        rem[1] = 1; plen[1] = 3;
        rem[2] = 1; plen[2] = 1;
        for (int c = 0; c < 40; c++) begin
            drive_srcs();
            #1;
            if (rem[1] > 0) begin
                n_checks++; if (s_ready[2] !== 1'b0) begin n_fail++; $display("FAIL lock_src2_ready cycle %0d got %b want 0", c, s_ready[2]); end
            end
            tick();
            if (m_valid) begin gs.push_back(int'(m_src)); gd.push_back(m_data); end
            update_srcs();
            if (gap[1] > 0) gap[1]--;
            if (mdl_acc && mdl_acc_src == 1 && bidx[1] == 1) gap[1] = 2;
        end
        n_checks++;
        if (gs.size() != 4) begin
            n_fail++; $display("FAIL lock_beat_count got %0d want 4", gs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (gs[k] != exp_src[k]) begin n_fail++; $display("FAIL lock_order[%0d] got %0d want %0d", k, gs[k], exp_src[k]); end
            end
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (gd[k] !== beat_data(1, 0, k)) begin n_fail++; $display("FAIL lock_data[%0d] got %h want %h", k, gd[k], beat_data(1, 0, k)); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got[$];
        int bp = 0;
        bit started = 0;
        apply_reset();
        rem[3] = 1; plen[3] = 4;
        for (int c = 0; c < 40; c++) begin
            m_ready = (bp == 0);
            drive_srcs();
            #1;
            if (m_valid && m_ready) got.push_back(m_data);
            if (bp > 0) begin
                n_checks++; if (s_ready[3] !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready got %b want 0", s_ready[3]); end
                n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid got %b want 1", m_valid); end
                n_checks++; if (m_data !== beat_data(3, 0, 0)) begin n_fail++; $display("FAIL bp_hold_data got %h want %h", m_data, beat_data(3, 0, 0)); end
                n_checks++; if (m_src !== 2'd3) begin n_fail++; $display("FAIL bp_hold_src got %0d want 3", m_src); end
                n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL bp_hold_last got %b want 0", m_last); end
            end
            tick();
            update_srcs();
            if (bp > 0) bp--;
            if (!started && mdl_acc) begin started = 1; bp = 5; end
        end
        n_checks++;
        if (got.size() != 4) begin
            n_fail++; $display("FAIL bp_beat_count got %0d want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (got[k] !== beat_data(3, 0, k)) begin n_fail++; $display("FAIL bp_beat[%0d] got %h want %h", k, got[k], beat_data(3, 0, k)); end
            end
        end
    endtask

    task automatic test_wrap_skip();
        int gs[$];
        int exp_src[3] = '{2, 0, 1};
        bit phase = 0, chk_next = 0;
        apply_reset();
        rem[2] = 1; plen[2] = 1;
        for (int c = 0; c < 20; c++) begin
            drive_srcs();
            tick();
            if (chk_next) begin
                n_checks++; if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant got %b want 0001", s_ready); end
                chk_next = 0;
            end
            if (m_valid) gs.push_back(int'(m_src));
            update_srcs();
            if (!phase && rem[2] == 0) begin
                rem[0] = 1; rem[1] = 1; phase = 1; chk_next = 1;
            end
        end
        n_checks++;
        if (gs.size() != 3) begin
            n_fail++; $display("FAIL wrap_beat_count got %0d want 3", gs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (gs[k] != exp_src[k]) begin n_fail++; $display("FAIL wrap_order[%0d] got %0d want %0d", k, gs[k], exp_src[k]); end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit done = 0;
        apply_reset();
        rem[2] = 1; plen[2] = 4;
        for (int c = 0; c < 20 && !done; c++) begin
            drive_srcs();
            tick();
            update_srcs();
            if (bidx[2] == 2) done = 1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL rstmid_reach_beat2 got timeout want beat 2"); end
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %b want 1", m_valid); end
        rem[0] = 1; plen[0] = 1;
        drive_srcs();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid got %b want 0", m_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_checks++; if (s_ready !== '0) begin n_fail++; $display("FAIL rstmid_s_ready got %b want 0000", s_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        bidx[2] = 0;
        drive_srcs();
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_regrant_busy got %b want 1", busy); end
        n_checks++; if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_regrant got %b want 0001", s_ready); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < N; i++) begin rem[i] = 1000; plen[i] = $urandom_range(1, 4); end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) gap[i] = ($urandom_range(0, 5) == 0) ? 1 : 0;
            m_ready = ($urandom_range(0, 3) != 0);
            drive_srcs();
            #1;
            n_checks++; if (s_ready !== mdl_ready()) begin n_fail++; $display("FAIL rnd_s_ready cycle %0d got %b want %b", c, s_ready, mdl_ready()); end
            tick();
            n_checks++; if (busy !== mdl_busy) begin n_fail++; $display("FAIL rnd_busy cycle %0d got %b want %b", c, busy, mdl_busy); end
            n_checks++; if (m_valid !== mdl_mv) begin n_fail++; $display("FAIL rnd_m_valid cycle %0d got %b want %b", c, m_valid, mdl_mv); end
            if (mdl_mv) begin
                n_checks++; if (m_data !== mdl_md) begin n_fail++; $display("FAIL rnd_m_data cycle %0d got %h want %h", c, m_data, mdl_md); end
                n_checks++; if (m_last !== mdl_ml) begin n_fail++; $display("FAIL rnd_m_last cycle %0d got %b want %b", c, m_last, mdl_ml); end
                n_checks++; if (int'(m_src) != mdl_ms) begin n_fail++; $display("FAIL rnd_m_src cycle %0d got %0d want %0d", c, m_src, mdl_ms); end
            end
            if (mdl_acc && mdl_acc_last) plen[mdl_acc_src] = $urandom_range(1, 4);
            update_srcs();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_ready = 1'b1;
        clear_srcs();
        model_reset();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
